fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 119 +++++++++++
 tb/tb_fifo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Single-clock parameterised FIFO with registered read data and status flags.
// Reads have one-cycle latency; a write to a full FIFO is accepted only alongside a read.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     write_enable,
    input  logic                     read_enable,
    output logic [WIDTH-1:0]         data_o,
    output logic                     read_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_o_q, data_o_d;
    logic             read_valid_q, read_valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             do_read;
    logic             do_write;

    always_comb begin
        do_read  = read_enable && !empty_q;
        // A full FIFO still takes a write when the same edge frees a slot.
        do_write = write_enable && (!full_q || do_read);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_o_d     = data_o_q;
        read_valid_d = 1'b0;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_read) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            data_o_d     = mem_q[rd_ptr_q];
            read_valid_d = 1'b1;
        end

        if (do_write && !do_read) begin
            count_d = count_q + CW'(1);
        end else if (do_read && !do_write) begin
            count_d = count_q - CW'(1);
        end

        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == '0);
        almost_full_d = (count_d >= AF_C);
        overflow_d    = write_enable && !do_write;
        underflow_d   = read_enable && empty_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            data_o_q      <= '0;
            read_valid_q  <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_o_q      <= data_o_d;
            read_valid_q  <= read_valid_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage is not cleared; resetting the pointers makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o      = data_o_q;
    assign read_valid  = read_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus random traffic checked against a queue model.
module tb_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_i = '0;
    logic             write_enable = 1'b0;
    logic             read_enable = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic             read_valid, full, empty, almost_full, overflow, underflow;
    logic [4:0]       count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_data = '0;
    logic             m_rv = 1'b0, m_ov = 1'b0, m_un = 1'b0;

    fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .data_i(data_i),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_o(data_o), .read_valid(read_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("count",       32'(count),       32'(mq.size()));
        chk("full",        32'(full),        32'(mq.size() == DEPTH));
        chk("empty",       32'(empty),       32'(mq.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        chk("read_valid",  32'(read_valid),  32'(m_rv));
        chk("data_o",      32'(data_o),      32'(m_data));
        chk("overflow",    32'(overflow),    32'(m_ov));
        chk("underflow",   32'(underflow),   32'(m_un));
    endtask

    task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] d);
        logic acc_rd, acc_wr;
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        data_i       = d;
        @(posedge clk);
        acc_rd = re && (mq.size() > 0);
        acc_wr = we && ((mq.size() < DEPTH) || acc_rd);
        m_rv = acc_rd;
        m_ov = we && !acc_wr;
        m_un = re && (mq.size() == 0);
        if (acc_rd) m_data = mq.pop_front();
        if (acc_wr) mq.push_back(d);
        #1;
        chk_model();
    endtask

    task automatic do_reset(input logic we, input logic re);
        @(negedge clk);
        reset        = 1'b1;
        write_enable = we;
        read_enable  = re;
        data_i       = 8'hEE;
        @(posedge clk);
        mq.delete();
        m_data = '0;
        m_rv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
        #1;
        chk_model();
        @(negedge clk);
        reset        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        // reset and basic FIFO order
        do_reset(1'b0, 1'b0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(0, 1, 8'h00); chk("seq_11", 32'(data_o), 32'h11); chk("seq_rv1", 32'(read_valid), 32'd1);
        step(0, 1, 8'h00); chk("seq_22", 32'(data_o), 32'h22);
        step(0, 1, 8'h00); chk("seq_33", 32'(data_o), 32'h33);
        chk("seq_empty", 32'(empty), 32'd1);
        chk("seq_count0", 32'(count), 32'd0);
        step(0, 0, 8'h00); chk("hold_data", 32'(data_o), 32'h33); chk("hold_rv", 32'(read_valid), 32'd0);

        // fill to full, almost_full threshold, overflow
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, 8'(8'h40 + i));
            if (i == AF - 1) chk("af_below", 32'(almost_full), 32'd0);
            if (i == AF)     chk("af_at",    32'(almost_full), 32'd1);
            if (i == DEPTH - 1) chk("full_below", 32'(full), 32'd0);
        end
        chk("full_at16", 32'(full), 32'd1);
        step(1, 0, 8'hFF);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        step(0, 1, 8'h00);
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        chk("ovf_first", 32'(data_o), 32'h41);
        while (mq.size() > 0) step(0, 1, 8'h00);
        chk("ovf_last", 32'(data_o), 32'h50);

        // underflow, same-cycle write into empty FIFO
        step(0, 1, 8'h00);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_rv", 32'(read_valid), 32'd0);
        chk("unf_hold", 32'(data_o), 32'h50);
        step(1, 1, 8'hA5);
        chk("unf_wr_count", 32'(count), 32'd1);
        step(0, 1, 8'h00);
        chk("unf_a5", 32'(data_o), 32'hA5);

        // simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h60 + i));
        step(1, 1, 8'h5A);
        chk("rw_full_count", 32'(count), 32'd16);
        chk("rw_full_ovf", 32'(overflow), 32'd0);
        chk("rw_full_data", 32'(data_o), 32'h60);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'h00);
        chk("rw_older_last", 32'(data_o), 32'h6F);
        step(0, 1, 8'h00);
        chk("rw_5a", 32'(data_o), 32'h5A);

        // interleaved traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 8'($urandom));
            step(1, 1, 8'($urandom));
            step(0, (i % 3) != 0, 8'h00);
        end
        while (mq.size() > 0) step(0, 1, 8'h00);
        chk("wrap_drain_empty", 32'(empty), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // reset with count=9 and read pending
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h90 + i));
        chk("pre_rst_count", 32'(count), 32'd9);
        step(0, 1, 8'h00);
        do_reset(1'b1, 1'b1);
        chk("rst9_count", 32'(count), 32'd0);
        chk("rst9_empty", 32'(empty), 32'd1);
        chk("rst9_rv", 32'(read_valid), 32'd0);
        chk("rst9_data", 32'(data_o), 32'd0);
        step(1, 0, 8'h77);
        chk("post_rst_count", 32'(count), 32'd1);
        step(0, 1, 8'h00);
        chk("post_rst_data", 32'(data_o), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
